pb_led_pio: RTL
===============

# pb_led_pio

Parametrised pushbutton/LED peripheral for the BeMicro MAX 10 Nios II system. It replaces separate button and LED PIOs with one Avalon-MM slave that adds:
- synchronisation and debouncing of every button;
- press-edge capture with a maskable interrupt;
- per-LED blink under a programmable divider.

It sits inside the Qsys system on SYS_CLK. Its button inputs connect to PB and its LED outputs connect to USE_LED.

## Interface
- NUM_BUTTONS, 4: number of pushbutton inputs, 1..32
- NUM_LEDS, 8: number of LED outputs, 1..32
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a button change is accepted (10 ms at 50 MHz); must be ≥2
- BLINK_DIV_W, 24: width of the blink divider register
---
- SYS_CLK  in  1  system clock, 50 MHz
- RESET  in  1  asynchronous, active-high reset
- avs_address  in  3  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data; fixed read latency 1
- irq  out  1  interrupt, active-high, level
- PB  in  NUM_BUTTONS  raw buttons, active-low (pressed = 0)
- USE_LED  out  NUM_LEDS  LED drive, active-low (0 = lit)

## Operation
- Button path, per bit:
  - Two-flop synchroniser on PB, then inversion so that 1 = pressed.
  - Per-button counter, width clog2(DEBOUNCE_CYCLES). It clears whenever the synchronised value equals the debounced state. Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced state takes the synchronised value and the counter clears.
- Edge capture: EDGE[i] sets on a debounced 0→1 (press) of button i. Releases are not captured.
- irq = |(EDGE & IRQ_MASK), registered.
- Register map (word addresses). Unused bits read 0; writes to them are ignored.
  - 0 STATE: R, debounced pressed state [NUM_BUTTONS-1:0]; writes ignored.
  - 1 IRQ_MASK: RW [NUM_BUTTONS-1:0].
  - 2 EDGE: R; write-1-to-clear per bit.
  - 3 LED: RW [NUM_LEDS-1:0]; 1 = lit.
  - 4 BLINK_MASK: RW [NUM_LEDS-1:0], present only with macro.
  - 5 BLINK_DIV: RW [BLINK_DIV_W-1:0], present only with macro.
  - 6, 7: read 0, writes ignored.
- LED output: USE_LED = ~(LED & ~(BLINK_MASK & {NUM_LEDS{phase}})).
- Blink generator: free-running counter compared against BLINK_DIV.
  - When the counter equals BLINK_DIV, it clears and phase toggles.
  - BLINK_DIV = 0 forces phase to 0 and holds the counter at 0, so no blinking occurs.
  - Writing BLINK_DIV clears the counter. Phase is unchanged.

## Timing
- Reset values:
  - avs_readdata = 0, irq = 0, USE_LED all 1 (LEDs off).
  - All registers 0, debounced state 0 (not pressed), synchronisers 1 (released).
  - Counters 0, phase 0.
- Reset mid-debounce discards the partial count. Reset has immediate effect on all outputs.
- Read: the address is sampled on the avs_read cycle; avs_readdata is valid on the next cycle and holds until the next read.
- Write: takes effect at the end of the avs_write cycle. There is no waitrequest.
- A simultaneous read and write to the same address returns the pre-write value.
- Button latency: a PB change that stays stable is reflected in STATE exactly 2 + DEBOUNCE_CYCLES cycles after the first changed sample.
  - A bounce shorter than DEBOUNCE_CYCLES produces no STATE change and no edge.
- EDGE sets in the same cycle that STATE rises. irq asserts one cycle later if the bit is masked in.
- Simultaneous events:
  - W1C of EDGE[i] in the same cycle that a new edge occurs on i: EDGE[i] stays set (set wins).
  - IRQ_MASK write and edge in the same cycle: irq in the next cycle uses the new mask.
- LED register write: USE_LED changes the following cycle.
- Blink half-period = BLINK_DIV+1 cycles.
- Changing BLINK_DIV while phase = 1 keeps phase = 1 until the new terminal count.

## Configuration
- PB_LED_BLINK_EN defined:
  - Blink counter, phase, BLINK_MASK and BLINK_DIV are built.
  - Addresses 4/5 are read/write.
- PB_LED_BLINK_EN undefined:
  - No blink logic is built; phase is a constant 0.
  - Addresses 4/5 read 0 and ignore writes.
  - USE_LED = ~LED.

## Test plan
- Reset: assert RESET mid-sim with PB = 4'b1111 → USE_LED = 8'hFF, irq = 0, and reads of addresses 0–7 all return 0.
- Debounce (DEBOUNCE_CYCLES = 16): hold PB[0] at 0 for 10 cycles, then 1 → STATE stays 0, EDGE = 0. Then hold PB[0] at 0 for 30 cycles → STATE = 1 at exactly cycle 18 and EDGE = 1.
- Interrupt: IRQ_MASK = 4'b0100, press PB[2] → irq = 1 one cycle after EDGE[2] sets. Write EDGE = 4'b0100 → irq = 0. Press PB[1] → EDGE[1] = 1, irq stays 0.
- Set-wins: time a W1C of EDGE[3] to the exact cycle PB[3] debounces pressed → EDGE[3] reads 1 afterward.
- LED/blink (macro on): LED = 8'hA5, BLINK_MASK = 8'h01, BLINK_DIV = 3 → USE_LED toggles between 8'h5A and 8'h5B every 4 cycles. BLINK_DIV = 0 → USE_LED held at 8'h5A.
- Macro off: write 8'h0F to address 4 and read it back → read returns 0. LED = 8'h0F → USE_LED = 8'hF0 is constant.

Source files
------------

// File: rtl/pb_led_pio_if.sv
// pb_led_pio_if: Avalon-MM slave port (word address, read latency 1, no waitrequest)
interface pb_led_pio_if;
   logic [2:0]  avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [31:0] avs_readdata;
   modport master (output avs_address, avs_read, avs_write, avs_writedata, input avs_readdata);
   modport slave (input avs_address, avs_read, avs_write, avs_writedata, output avs_readdata);
endinterface

// File: rtl/pb_led_pio.sv
// pb_led_pio: pushbutton/LED Avalon-MM peripheral; debounce, press-edge IRQ, LED blink built only with PB_LED_BLINK_EN
module pb_led_pio #(
   parameter int NUM_BUTTONS     = 4,
   parameter int NUM_LEDS        = 8,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int BLINK_DIV_W     = 24
) (
   input  logic                   SYS_CLK,
   input  logic                   RESET,
   pb_led_pio_if.slave            avs,
   output logic                   irq,
   input  logic [NUM_BUTTONS-1:0] PB,
   output logic [NUM_LEDS-1:0]    USE_LED
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   logic [NUM_BUTTONS-1:0] sync_1, sync_2, pressed, state, state_nx, edges, irq_mask, w1c;
   logic [CW-1:0]          cnt [NUM_BUTTONS];
   logic [CW-1:0]          cnt_nx [NUM_BUTTONS];
   logic [NUM_LEDS-1:0]    led, blink_mask;
   logic [BLINK_DIV_W-1:0] blink_div;
   logic [31:0]            rd_mux;
   logic                   phase, unused_wd;

   assign pressed   = ~sync_2;
   assign w1c       = (avs.avs_write && avs.avs_address == 3'd2) ? avs.avs_writedata[NUM_BUTTONS-1:0] : '0;
   assign unused_wd = ^avs.avs_writedata;
   assign USE_LED   = ~(led & ~(blink_mask & {NUM_LEDS{phase}}));

   // Two-flop synchroniser; resets to the released level
   always_ff @(posedge SYS_CLK or posedge RESET)
      if (RESET) {sync_2, sync_1} <= '1;
      else {sync_2, sync_1} <= {sync_1, PB};

   // A button change is accepted after DEBOUNCE_CYCLES consecutive differing samples
   always_comb begin
      state_nx = state;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         cnt_nx[i] = (pressed[i] == state[i] || cnt[i] == CNT_LAST) ? '0 : cnt[i] + 1'b1;
         if (pressed[i] != state[i] && cnt[i] == CNT_LAST) state_nx[i] = pressed[i];
      end
   end

   // Debounce counters and accepted button state
   always_ff @(posedge SYS_CLK or posedge RESET)
      if (RESET) begin
         state <= '0;
         cnt   <= '{default: '0};
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end

   // Control registers; a new press beats a same-cycle write-1-to-clear, irq follows the registered EDGE and mask
   always_ff @(posedge SYS_CLK or posedge RESET)
      if (RESET) begin
         irq_mask <= '0;
         edges    <= '0;
         led      <= '0;
         irq      <= 1'b0;
      end else begin
         if (avs.avs_write && avs.avs_address == 3'd1) irq_mask <= avs.avs_writedata[NUM_BUTTONS-1:0];
         if (avs.avs_write && avs.avs_address == 3'd3) led <= avs.avs_writedata[NUM_LEDS-1:0];
         edges <= (edges & ~w1c) | (state_nx & ~state);
         irq   <= |(edges & irq_mask);
      end

`ifdef PB_LED_BLINK_EN
   logic [BLINK_DIV_W-1:0] blink_cnt;

   // Blink generator: half-period of BLINK_DIV+1 cycles, a zero divider parks phase at 0
   always_ff @(posedge SYS_CLK or posedge RESET)
      if (RESET) begin
         blink_mask <= '0;
         blink_div  <= '0;
         blink_cnt  <= '0;
         phase      <= 1'b0;
      end else begin
         if (avs.avs_write && avs.avs_address == 3'd4) blink_mask <= avs.avs_writedata[NUM_LEDS-1:0];
         if (avs.avs_write && avs.avs_address == 3'd5) begin
            blink_div <= avs.avs_writedata[BLINK_DIV_W-1:0];
            blink_cnt <= '0;
         end else if (blink_div == '0) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
         end else if (blink_cnt == blink_div) begin
            blink_cnt <= '0;
            phase     <= ~phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
`else
   assign blink_mask = '0;
   assign blink_div  = '0;
   assign phase      = 1'b0;
`endif

   // Read mux; unused bits and unmapped addresses read 0
   always_comb begin
      rd_mux = '0;
      case (avs.avs_address)
         3'd0:    rd_mux[NUM_BUTTONS-1:0] = state;
         3'd1:    rd_mux[NUM_BUTTONS-1:0] = irq_mask;
         3'd2:    rd_mux[NUM_BUTTONS-1:0] = edges;
         3'd3:    rd_mux[NUM_LEDS-1:0]    = led;
         3'd4:    rd_mux[NUM_LEDS-1:0]    = blink_mask;
         3'd5:    rd_mux[BLINK_DIV_W-1:0] = blink_div;
         default: rd_mux = '0;
      endcase
   end

   // Read data captured on the read cycle (pre-write value) and held until the next read
   always_ff @(posedge SYS_CLK or posedge RESET)
      if (RESET) avs.avs_readdata <= '0;
      else if (avs.avs_read) avs.avs_readdata <= rd_mux;
endmodule
